// File: rtl/cnn_crop_scheduler.sv
// rtl/cnn_crop_scheduler.sv - Crop sequencer driving the CNN core over a stored frame
// One core pass per crop: start pulse, raster window stream, per-channel capture, packed result.
module cnn_crop_scheduler #(
  parameter int FP_TOTAL = 16,
  parameter int IN_ROWS  = 100,
  parameter int IN_COLS  = 160,
  parameter int OUT_ROWS = 48,
  parameter int OUT_COLS = 48,
  parameter int NUM_OUT  = 5,
  parameter int ADDR_W   = 14,
  parameter int Y_W      = 7,
  parameter int X_W      = 8
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [Y_W-1:0]              crop_y,
  input  logic [X_W-1:0]              crop_x,
  input  logic                        crop_valid,
  output logic                        crop_ready,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [FP_TOTAL-1:0]         mem_rd_data,
  output logic                        cnn_ap_start,
  input  logic                        cnn_ap_done,
  output logic [FP_TOTAL-1:0]         cnn_in_TDATA,
  output logic                        cnn_in_TVALID,
  input  logic                        cnn_in_TREADY,
  input  logic [NUM_OUT*FP_TOTAL-1:0] cnn_out_TDATA,
  input  logic [NUM_OUT-1:0]          cnn_out_TVALID,
  output logic [NUM_OUT-1:0]          cnn_out_TREADY,
  output logic [NUM_OUT*FP_TOTAL-1:0] res_data,
  output logic                        res_clamped,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        busy
);

  localparam int TOTAL = OUT_ROWS * OUT_COLS;
  localparam int R_W   = $clog2(OUT_ROWS + 1);
  localparam int C_W   = $clog2(OUT_COLS);
  localparam int N_W   = $clog2(TOTAL + 1);
  localparam logic [Y_W-1:0]    Y_MAX      = Y_W'(IN_ROWS - OUT_ROWS);
  localparam logic [X_W-1:0]    X_MAX      = X_W'(IN_COLS - OUT_COLS);
  localparam logic [N_W-1:0]    N_TOTAL    = N_W'(TOTAL);
  localparam logic [N_W-1:0]    N_LAST     = N_W'(TOTAL - 1);
  localparam logic [C_W-1:0]    C_LAST     = C_W'(OUT_COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IN_COLS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_COLLECT,
    S_RESULT
  } state_t;

  state_t                      state_q, state_d;
  logic [Y_W-1:0]              y0_q, y0_d;
  logic [X_W-1:0]              x0_q, x0_d;
  logic                        clamped_q, clamped_d;
  logic [R_W-1:0]              r_q, r_d;
  logic [C_W-1:0]              c_q, c_d;
  logic [N_W-1:0]              issued_q, issued_d;
  logic [N_W-1:0]              accepted_q, accepted_d;
  logic                        inflight_q, inflight_d;
  logic [FP_TOTAL-1:0]         fifo0_q, fifo0_d;
  logic [FP_TOTAL-1:0]         fifo1_q, fifo1_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic [NUM_OUT-1:0]          got_q, got_d;
  logic                        done_seen_q, done_seen_d;
  logic [NUM_OUT*FP_TOTAL-1:0] res_buf_q, res_buf_d;

  logic [FP_TOTAL-1:0] fifo_head;
  logic                pop;
  logic [2:0]          occ_next;
  logic [ADDR_W-1:0]   addr_calc;
  logic                cap_state;
  logic [NUM_OUT-1:0]  cap;

  assign addr_calc = (ADDR_W'(y0_q) + ADDR_W'(r_q)) * ROW_STRIDE
                   + ADDR_W'(x0_q) + ADDR_W'(c_q);

  always_comb begin
    state_d     = state_q;
    y0_d        = y0_q;
    x0_d        = x0_q;
    clamped_d   = clamped_q;
    r_d         = r_q;
    c_d         = c_q;
    issued_d    = issued_q;
    accepted_d  = accepted_q;
    inflight_d  = 1'b0;
    fifo0_d     = fifo0_q;
    fifo1_d     = fifo1_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    got_d       = got_q;
    done_seen_d = done_seen_q;
    res_buf_d   = res_buf_q;

    busy         = (state_q != S_IDLE);
    crop_ready   = (state_q == S_IDLE) && ap_rst_n;
    cnn_ap_start = (state_q == S_START);
    res_valid    = (state_q == S_RESULT);
    res_data     = res_valid ? res_buf_q : '0;
    res_clamped  = res_valid && clamped_q;

    fifo_head     = rd_ptr_q ? fifo1_q : fifo0_q;
    cnn_in_TVALID = (cnt_q != 2'd0);
    cnn_in_TDATA  = cnn_in_TVALID ? fifo_head : '0;
    pop           = cnn_in_TVALID && cnn_in_TREADY;

    // Occupancy after this cycle's pop plus the read already in flight; the pop
    // credit is what lets the stream sustain one pixel per cycle.
    occ_next  = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    mem_rd_en = (state_q == S_STREAM) && (occ_next < 3'd2) && (issued_q < N_TOTAL);
    mem_addr  = mem_rd_en ? addr_calc : '0;

    if (mem_rd_en) begin
      issued_d = issued_q + N_W'(1);
      if (c_q == C_LAST) begin
        c_d = '0;
        r_d = r_q + R_W'(1);
      end else begin
        c_d = c_q + C_W'(1);
      end
    end
    inflight_d = mem_rd_en;

    if (inflight_q) begin
      if (wr_ptr_q) fifo1_d = mem_rd_data;
      else          fifo0_d = mem_rd_data;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d   = ~rd_ptr_q;
      accepted_d = accepted_q + N_W'(1);
    end
    cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};

    cap_state      = (state_q == S_STREAM) || (state_q == S_COLLECT);
    cnn_out_TREADY = cap_state ? ~got_q : '0;
    cap            = cnn_out_TVALID & cnn_out_TREADY;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (cap[k]) res_buf_d[k*FP_TOTAL +: FP_TOTAL] = cnn_out_TDATA[k*FP_TOTAL +: FP_TOTAL];
    end
    got_d = got_q | cap;

    // Done can land before, during or after output capture, so it is sticky.
    if (busy && cnn_ap_done) done_seen_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (crop_valid && crop_ready) begin
          y0_d      = (crop_y > Y_MAX) ? Y_MAX : crop_y;
          x0_d      = (crop_x > X_MAX) ? X_MAX : crop_x;
          clamped_d = (crop_y > Y_MAX) || (crop_x > X_MAX);
          state_d   = S_START;
        end
      end
      S_START: begin
        r_d        = '0;
        c_d        = '0;
        issued_d   = '0;
        accepted_d = '0;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        if (pop && (accepted_q == N_LAST)) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if ((&got_d) && (done_seen_q || cnn_ap_done)) state_d = S_RESULT;
      end
      S_RESULT: begin
        if (res_ready) begin
          got_d       = '0;
          done_seen_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      y0_q        <= '0;
      x0_q        <= '0;
      clamped_q   <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      inflight_q  <= 1'b0;
      fifo0_q     <= '0;
      fifo1_q     <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      got_q       <= '0;
      done_seen_q <= 1'b0;
      res_buf_q   <= '0;
    end else begin
      state_q     <= state_d;
      y0_q        <= y0_d;
      x0_q        <= x0_d;
      clamped_q   <= clamped_d;
      r_q         <= r_d;
      c_q         <= c_d;
      issued_q    <= issued_d;
      accepted_q  <= accepted_d;
      inflight_q  <= inflight_d;
      fifo0_q     <= fifo0_d;
      fifo1_q     <= fifo1_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      got_q       <= got_d;
      done_seen_q <= done_seen_d;
      res_buf_q   <= res_buf_d;
    end
  end

endmodule

// File: tb/tb_cnn_crop_scheduler.sv
// tb/tb_cnn_crop_scheduler.sv - Directed self-checking bench for cnn_crop_scheduler
module tb_cnn_crop_scheduler;
  localparam int FP = 16;
  localparam int NO = 5;
  localparam int AW = 14;
  localparam int YW = 7;
  localparam int XW = 8;
  localparam int IN_ROWS = 100;
  localparam int IN_COLS = 160;
  localparam int OR = 48;
  localparam int OC = 48;
  localparam int TOTAL = OR * OC;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic [YW-1:0] crop_y;
  logic [XW-1:0] crop_x;
  logic crop_valid, crop_ready;
  logic mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [FP-1:0] mem_rd_data;
  logic cnn_ap_start, cnn_ap_done;
  logic [FP-1:0] cnn_in_TDATA;
  logic cnn_in_TVALID, cnn_in_TREADY;
  logic [NO*FP-1:0] cnn_out_TDATA;
  logic [NO-1:0] cnn_out_TVALID, cnn_out_TREADY;
  logic [NO*FP-1:0] res_data;
  logic res_clamped, res_valid, res_ready, busy;

  int errors = 0;
  int checks = 0;
  logic tready_rand = 1'b0;

  // Bench-side model of the current crop and its observed traffic
  int my0, mx0;
  bit mclamped;
  int pix_idx, rd_idx, start_cnt, stalls, results, cyc;
  bit [NO-1:0] mgot;
  bit mdone;
  logic [FP-1:0] mwords [NO];
  bit prev_stall, prev_res_hold;
  logic [FP-1:0] prev_tdata;
  logic [NO*FP-1:0] prev_res, last_res_data;
  bit last_res_clamped;
  int first_addr, last_addr, first_rd_cyc, first_acc_cyc, last_acc_cyc;

  cnn_crop_scheduler dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .crop_y(crop_y), .crop_x(crop_x), .crop_valid(crop_valid), .crop_ready(crop_ready),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .cnn_ap_start(cnn_ap_start), .cnn_ap_done(cnn_ap_done),
    .cnn_in_TDATA(cnn_in_TDATA), .cnn_in_TVALID(cnn_in_TVALID), .cnn_in_TREADY(cnn_in_TREADY),
    .cnn_out_TDATA(cnn_out_TDATA), .cnn_out_TVALID(cnn_out_TVALID), .cnn_out_TREADY(cnn_out_TREADY),
    .res_data(res_data), .res_clamped(res_clamped), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  // Frame memory: each word holds its own address, one-cycle read latency
  always @(posedge ap_clk) if (mem_rd_en) mem_rd_data <= 16'(mem_addr);

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_addr(input int i);
    return (my0 + i / OC) * IN_COLS + mx0 + i % OC;
  endfunction

  initial begin
    cnn_in_TREADY = 1'b1;
    forever begin
      @(posedge ap_clk); #1;
      cnn_in_TREADY = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge ap_clk) begin
    cyc++;
    if (!ap_rst_n) begin
      pix_idx = 0; rd_idx = 0; start_cnt = 0; mgot = '0; mdone = 0;
      prev_stall = 0; prev_res_hold = 0;
    end else begin
      if (!(pix_idx == TOTAL && (&mgot) && mdone)) check("res_valid_early", res_valid, 0);
      if (prev_stall) begin
        stalls++;
        check("tvalid_hold", cnn_in_TVALID, 1);
        check("tdata_hold", cnn_in_TDATA, prev_tdata);
      end
      if (prev_res_hold) begin
        check("res_valid_hold", res_valid, 1);
        check("res_data_hold", res_data == prev_res, 1);
        check("crop_ready_in_result", crop_ready, 0);
      end
      if (mem_rd_en) begin
        check("read_count", rd_idx < TOTAL, 1);
        check("mem_addr", mem_addr, exp_addr(rd_idx));
        if (rd_idx == 0) begin first_addr = mem_addr; first_rd_cyc = cyc; end
        last_addr = mem_addr;
        rd_idx++;
      end
      if (cnn_in_TVALID && cnn_in_TREADY) begin
        check("pixel_count", pix_idx < TOTAL, 1);
        check("pixel", cnn_in_TDATA, exp_addr(pix_idx));
        if (pix_idx == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        pix_idx++;
      end
      prev_stall = cnn_in_TVALID && !cnn_in_TREADY;
      prev_tdata = cnn_in_TDATA;
      if (cnn_ap_start) start_cnt++;
      if (busy && cnn_ap_done) mdone = 1;
      for (int k = 0; k < NO; k++) begin
        if (mgot[k] && cnn_out_TVALID[k]) check("dup_tready", cnn_out_TREADY[k], 0);
        if (cnn_out_TVALID[k] && cnn_out_TREADY[k]) begin
          mgot[k] = 1;
          mwords[k] = cnn_out_TDATA[k*FP +: FP];
        end
      end
      if (res_valid && res_ready) begin
        for (int k = 0; k < NO; k++) check("res_slice", res_data[k*FP +: FP], mwords[k]);
        check("res_clamped", res_clamped, mclamped);
        check("ap_start_pulses", start_cnt, 1);
        last_res_data = res_data;
        last_res_clamped = res_clamped;
        results++;
        mgot = '0; mdone = 0; start_cnt = 0;
      end
      prev_res_hold = res_valid && !res_ready;
      prev_res = res_data;
      if (crop_valid && crop_ready) begin
        my0 = int'(crop_y); if (my0 > IN_ROWS - OR) my0 = IN_ROWS - OR;
        mx0 = int'(crop_x); if (mx0 > IN_COLS - OC) mx0 = IN_COLS - OC;
        mclamped = (int'(crop_y) > IN_ROWS - OR) || (int'(crop_x) > IN_COLS - OC);
        pix_idx = 0; rd_idx = 0;
      end
    end
  end

  task automatic send_crop(input int y, input int x);
    int n = 0;
    crop_y = YW'(y); crop_x = XW'(x); crop_valid = 1'b1;
    @(negedge ap_clk);
    while (!crop_ready && n < 5000) begin @(negedge ap_clk); n++; end
    check("crop_accept", crop_ready, 1);
    @(posedge ap_clk); #1;
    crop_valid = 1'b0;
  endtask

  task automatic wait_stream();
    int n = 0;
    while (pix_idx < TOTAL && n < 20000) begin @(posedge ap_clk); #1; n++; end
    check("stream_len", pix_idx, TOTAL);
  endtask

  task automatic send_word(input int k, input logic [FP-1:0] val);
    int n = 0;
    cnn_out_TDATA[k*FP +: FP] = val;
    cnn_out_TVALID[k] = 1'b1;
    @(negedge ap_clk);
    while (!cnn_out_TREADY[k] && n < 100) begin @(negedge ap_clk); n++; end
    check("out_accept", cnn_out_TREADY[k], 1);
    @(posedge ap_clk); #1;
    cnn_out_TVALID[k] = 1'b0;
  endtask

  task automatic pulse_done();
    cnn_ap_done = 1'b1;
    @(posedge ap_clk); #1;
    cnn_ap_done = 1'b0;
  endtask

  task automatic wait_result();
    int n = 0;
    int r0 = results;
    while (results == r0 && n < 500) begin @(posedge ap_clk); #1; n++; end
    check("result_seen", results, r0 + 1);
  endtask

  task automatic words_in_order(input int base);
    for (int k = 0; k < NO; k++) send_word(k, FP'(base + k));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    crop_valid = 0; crop_y = '0; crop_x = '0; cnn_ap_done = 0;
    cnn_out_TVALID = '0; cnn_out_TDATA = '0; res_ready = 1; mem_rd_data = '0;
    repeat (3) @(posedge ap_clk); #1;
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("idle_crop_ready", crop_ready, 1);
    check("idle_busy", busy, 0);

    // Unclamped crop, TREADY held high
    send_crop(10, 10);
    wait_stream();
    check("c1_first_addr", first_addr, 1610);
    check("c1_last_addr", last_addr, 9177);
    check("c1_fill_latency", first_acc_cyc - first_rd_cyc, 2);
    check("c1_burst_cycles", last_acc_cyc - first_acc_cyc + 1, 2304);
    words_in_order(1);
    pulse_done();
    wait_result();
    for (int k = 0; k < NO; k++) check("c1_slice", last_res_data[k*FP +: FP], k + 1);
    check("c1_clamped", last_res_clamped, 0);

    // Origin beyond both limits
    send_crop(80, 150);
    wait_stream();
    check("c2_first_addr", first_addr, 8432);
    check("c2_last_addr", last_addr, 15999);
    words_in_order(100);
    pulse_done();
    wait_result();
    check("c2_clamped", last_res_clamped, 1);
    check("c2_slice0", last_res_data[15:0], 100);

    // Random core back-pressure
    tready_rand = 1'b1;
    send_crop(33, 77);
    wait_stream();
    tready_rand = 1'b0;
    check("c3_first_addr", first_addr, 5357);
    check("c3_saw_stalls", stalls > 0, 1);
    words_in_order(200);
    pulse_done();
    wait_result();
    check("c3_clamped", last_res_clamped, 0);

    // Done first, channels out of order, duplicate word held off
    send_crop(5, 3);
    wait_stream();
    pulse_done();
    send_word(4, 16'h0044);
    cnn_out_TDATA[4*FP +: FP] = 16'hBEEF;
    cnn_out_TVALID[4] = 1'b1;
    repeat (3) begin @(negedge ap_clk); check("c4_dup_held", cnn_out_TREADY[4], 0); end
    @(posedge ap_clk); #1;
    cnn_out_TVALID[4] = 1'b0;
    send_word(0, 16'h0010);
    @(posedge ap_clk); #1;
    send_word(2, 16'h0012);
    @(posedge ap_clk); #1;
    send_word(1, 16'h0011);
    repeat (2) begin @(negedge ap_clk); check("c4_no_early_result", res_valid, 0); end
    @(posedge ap_clk); #1;
    send_word(3, 16'h0013);
    wait_result();
    check("c4_slice4", last_res_data[4*FP +: FP], 16'h0044);
    check("c4_slice0", last_res_data[0 +: FP], 16'h0010);
    check("c4_slice3", last_res_data[3*FP +: FP], 16'h0013);

    // Result back-pressure with a pending request
    send_crop(20, 30);
    wait_stream();
    res_ready = 1'b0;
    words_in_order(300);
    pulse_done();
    n = 0;
    while (!res_valid && n < 500) begin @(posedge ap_clk); #1; n++; end
    check("c5_res_valid_up", res_valid, 1);
    crop_y = 7'd1; crop_x = 8'd2; crop_valid = 1'b1;
    repeat (50) begin
      @(negedge ap_clk);
      check("c5_hold_valid", res_valid, 1);
      check("c5_hold_crop_ready", crop_ready, 0);
    end
    @(posedge ap_clk); #1;
    res_ready = 1'b1;
    @(negedge ap_clk);
    check("c5_handshake", res_valid, 1);
    @(negedge ap_clk);
    check("c5_next_accept", crop_ready, 1);
    @(posedge ap_clk); #1;
    crop_valid = 1'b0;
    @(negedge ap_clk);
    check("c5_next_start", cnn_ap_start, 1);
    @(posedge ap_clk); #1;
    wait_stream();
    check("c5b_first_addr", first_addr, 162);
    words_in_order(400);
    pulse_done();
    wait_result();

    // Reset in the middle of a stream
    send_crop(40, 100);
    n = 0;
    while (pix_idx < 700 && n < 5000) begin @(posedge ap_clk); #1; n++; end
    check("c6_reached_700", pix_idx >= 700, 1);
    n = results;
    ap_rst_n = 1'b0;
    #1;
    check("rst6_crop_ready", crop_ready, 0);
    check("rst6_mem_rd_en", mem_rd_en, 0);
    check("rst6_mem_addr", mem_addr, 0);
    check("rst6_ap_start", cnn_ap_start, 0);
    check("rst6_tvalid", cnn_in_TVALID, 0);
    check("rst6_tdata", cnn_in_TDATA, 0);
    check("rst6_out_tready", cnn_out_TREADY, 0);
    check("rst6_res_valid", res_valid, 0);
    check("rst6_res_data", res_data == '0, 1);
    check("rst6_res_clamped", res_clamped, 0);
    check("rst6_busy", busy, 0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    check("rst6_idle_ready", crop_ready, 1);
    check("rst6_no_result", results, n);
    send_crop(0, 0);
    wait_stream();
    check("c6_first_addr", first_addr, 0);
    check("c6_last_addr", last_addr, 47 * 160 + 47);
    words_in_order(500);
    pulse_done();
    wait_result();
    check("c6_slice2", last_res_data[2*FP +: FP], 502);

    repeat (3) @(posedge ap_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cnn_crop_scheduler.md
Name: cnn_crop_scheduler

Overview:
Sequences the HLS CNN core (myproject_small) over a stored frame. It accepts crop-origin requests and runs one CNN pass per crop. For each crop it pulses ap_start, streams the OUT_ROWS x OUT_COLS crop window from the frame memory into the core's input AXI-stream, and collects the 5 per-channel output words. It then emits one packed result word per crop. It sits between the frame buffer / crop-request source and the CNN core.

Parameters:
FP_TOTAL, 16, pixel/output word width
IN_ROWS, 100, frame rows
IN_COLS, 160, frame columns
OUT_ROWS, 48, crop rows
OUT_COLS, 48, crop columns
NUM_OUT, 5, CNN output channels
ADDR_W, 14, frame memory address width (>= clog2(IN_ROWS*IN_COLS))
Y_W, 7, crop row-origin width
X_W, 8, crop column-origin width

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
crop_y  in  Y_W  requested crop row origin
crop_x  in  X_W  requested crop column origin
crop_valid  in  1  crop request valid
crop_ready  out  1  scheduler can accept request
mem_rd_en  out  1  frame memory read strobe
mem_addr  out  ADDR_W  frame memory read address
mem_rd_data  in  FP_TOTAL  read data, valid exactly 1 cycle after mem_rd_en
cnn_ap_start  out  1  start pulse to core
cnn_ap_done  in  1  core done
cnn_in_TDATA  out  FP_TOTAL  pixel to core
cnn_in_TVALID  out  1  pixel valid
cnn_in_TREADY  in  1  core accepts pixel
cnn_out_TDATA  in  NUM_OUT*FP_TOTAL  channel k at bits [k*FP_TOTAL +: FP_TOTAL]
cnn_out_TVALID  in  NUM_OUT  per-channel valid
cnn_out_TREADY  out  NUM_OUT  per-channel ready
res_data  out  NUM_OUT*FP_TOTAL  packed result, channel k in slice k
res_clamped  out  1  origin was clamped for this result
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, ap_rst_n=0): state=IDLE. All outputs 0 except crop_ready=1 in IDLE after reset release. Internal counters, flags and buffer are cleared. A reset mid-run abandons the crop; no partial result is emitted.
- States: IDLE -> START -> STREAM -> COLLECT -> RESULT -> IDLE.
- IDLE: crop_ready=1. On crop_valid&crop_ready, latch the origin.
  - Clamp y0 = min(crop_y, IN_ROWS-OUT_ROWS) and x0 = min(crop_x, IN_COLS-OUT_COLS).
  - Set clamped flag if either value was reduced.
  - Next state START.
- START: cnn_ap_start=1 for exactly 1 cycle. Clear the row/column counters r=c=0. Next state STREAM.
- STREAM:
  - mem_addr = (y0+r)*IN_COLS + (x0+c). Raster order, c fastest; c wraps at OUT_COLS-1 with r++.
  - A 2-entry skid FIFO absorbs the 1-cycle read latency.
  - Issue a read only when (FIFO occupancy + reads in flight) < 2 and issued < OUT_ROWS*OUT_COLS.
  - cnn_in_TVALID = FIFO non-empty and cnn_in_TDATA = FIFO head. Pop the FIFO on TVALID&TREADY.
  - With TREADY held at 1, throughput is 1 pixel/cycle after a 2-cycle fill.
  - TDATA holds stable while TVALID=1 and TREADY=0.
  - Leave STREAM once OUT_ROWS*OUT_COLS pixels have been accepted by the core.
- Output capture: cnn_out_TREADY[k] = (state in STREAM or COLLECT) and !got[k].
  - On TVALID[k]&TREADY[k], store slice k and set got[k].
  - Extra words on a channel that already has got[k] set are held off (TREADY=0).
- ap_done handling: cnn_ap_done is latched into done_seen in any non-IDLE state, because done may precede or follow output capture.
- COLLECT: advance to RESULT when every got[k]=1 and done_seen=1, counting same-cycle captures.
- RESULT: res_valid=1, with res_data and res_clamped held stable until res_valid&res_ready.
  - On handshake, clear got and done_seen and go to IDLE.
  - crop_ready stays 0 throughout RESULT, so a new request is never accepted the same cycle as the result handshake.
- Core back-pressure: TREADY=0 indefinitely just stalls the block. There is no timeout.
- Arithmetic: all address arithmetic is unsigned, in ADDR_W bits. Clamping guarantees no overflow.

Test Plan:
- Origin (10,10), TREADY=1, outputs 1..5 returned after the stream -> first mem_addr=1610, last=(57*160+57)=9177. Exactly 2304 pixels in raster order, one ap_start pulse, res_data slices = 1..5, res_clamped=0.
- Origin (80,150) -> clamped to (52,112), first addr=8432, res_clamped=1.
- Random TREADY on cnn_in, with memory content = address -> pixel stream is strictly increasing per row with no duplicates or drops, and TDATA is stable during stalls.
- ap_done asserted before any output word, outputs arrive on channels in order 4,0,2,1,3 across separate cycles -> result emitted only after channel 3 is captured. Values are correct per slice.
- res_ready=0 for 50 cycles with crop_valid=1 -> res_valid and res_data are held, crop_ready=0. After the handshake the next crop is accepted the following cycle.
- Assert ap_rst_n=0 mid-STREAM at pixel 700 -> all outputs 0 immediately, state IDLE. A new crop then runs cleanly from address origin with a single ap_start.
